// File: rtl/tmds_decoder.sv
// TMDS single-channel receiver: bit-alignment search, symbol decode, lock monitor.
// Define TMDS_DEC_ERRCNT_EN to enable the lock-loss counter on err_count_out.
module tmds_decoder #(
  parameter int CTRL_LOCK_COUNT = 8,
  parameter int SLIP_WAIT       = 16,
  parameter int LOCK_TIMEOUT    = 4096
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [9:0]  tmds_in,
  output logic [7:0]  data_out,
  output logic [1:0]  control_out,
  output logic        ve_out,
  output logic        locked_out,
  output logic [3:0]  slip_out,
  output logic [15:0] err_count_out
);

  localparam int RW = $clog2(CTRL_LOCK_COUNT) + 1;
  localparam int WW = $clog2(SLIP_WAIT) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [RW-1:0] RUN_MAX = RW'(CTRL_LOCK_COUNT);
  localparam logic [WW-1:0] WIN_END = WW'(SLIP_WAIT - 1);
  localparam logic [TW-1:0] TO_END  = TW'(LOCK_TIMEOUT - 1);

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  state_t        state;
  logic [9:0]    prev;
  logic [9:0]    sym;
  logic [3:0]    offset;
  logic          stale;
  logic [RW-1:0] run_cnt;
  logic [WW-1:0] win_cnt;
  logic [TW-1:0] to_cnt;

  logic [19:0]   cat;
  logic [19:0]   shifted;
  logic [3:0]    next_off;
  logic          is_ctrl;
  logic [1:0]    ctl;
  logic [7:0]    d;
  logic [7:0]    vid;
  logic [RW-1:0] run_nxt;
  logic          hit;
  logic          timeout;
  logic          decoding;

  assign cat      = {tmds_in, prev};
  assign shifted  = cat >> offset;
  assign next_off = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
  assign slip_out = offset;

  always_comb begin
    is_ctrl = 1'b1;
    ctl     = 2'b00;
    unique case (sym)
      TOK0:    ctl = 2'b00;
      TOK1:    ctl = 2'b01;
      TOK2:    ctl = 2'b10;
      TOK3:    ctl = 2'b11;
      default: is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    d      = sym[9] ? ~sym[7:0] : sym[7:0];
    vid    = '0;
    vid[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      vid[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // The symbol right after a slip was built with the old offset.
  always_comb begin
    run_nxt = '0;
    if (is_ctrl && !stale) begin
      run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
    end
  end

  assign hit      = (run_nxt == RUN_MAX);
  assign timeout  = (state == LOCKED) && !hit && (to_cnt == TO_END);
  assign decoding = (state == LOCKED) ? !timeout : hit;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= SEARCH;
      prev        <= '0;
      sym         <= '0;
      offset      <= '0;
      stale       <= 1'b0;
      run_cnt     <= '0;
      win_cnt     <= '0;
      to_cnt      <= '0;
      data_out    <= '0;
      control_out <= '0;
      ve_out      <= 1'b0;
      locked_out  <= 1'b0;
    end else begin
      prev    <= tmds_in;
      sym     <= shifted[9:0];
      stale   <= 1'b0;
      run_cnt <= run_nxt;

      unique case (state)
        SEARCH: begin
          if (hit) begin
            state   <= LOCKED;
            win_cnt <= '0;
            to_cnt  <= '0;
          end else if (win_cnt == WIN_END) begin
            offset  <= next_off;
            win_cnt <= '0;
            run_cnt <= '0;
            stale   <= 1'b1;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (hit) begin
            to_cnt <= '0;
          end else if (timeout) begin
            state   <= SEARCH;
            offset  <= next_off;
            win_cnt <= '0;
            to_cnt  <= '0;
            run_cnt <= '0;
            stale   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
      endcase

      if (decoding) begin
        locked_out <= 1'b1;
        ve_out     <= !is_ctrl;
        if (is_ctrl) begin
          control_out <= ctl;
          data_out    <= '0;
        end else begin
          data_out <= vid;
        end
      end else begin
        locked_out  <= 1'b0;
        ve_out      <= 1'b0;
        control_out <= '0;
        data_out    <= '0;
      end
    end
  end

`ifdef TMDS_DEC_ERRCNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      err_cnt <= '0;
    end else if (timeout && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign err_count_out = err_cnt;
`else
  assign err_count_out = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock, decode, timeout, search and reset.
// Expected values come from a bench-side TMDS encoder and hand-derived timing.
module tb_tmds_decoder;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;
  localparam logic [9:0] VID0 = 10'b0100000000;

`ifdef TMDS_DEC_ERRCNT_EN
  localparam logic [15:0] ERR_EXP = 16'd1;
`else
  localparam logic [15:0] ERR_EXP = 16'd0;
`endif

  logic        clk;
  logic        rst;
  logic [9:0]  tmds;
  logic [7:0]  data;
  logic [1:0]  control;
  logic        ve;
  logic        locked;
  logic [3:0]  slip;
  logic [15:0] err_count;

  int passed = 0;
  int total  = 0;
  int disp   = 0;

  tmds_decoder dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .tmds_in       (tmds),
    .data_out      (data),
    .control_out   (control),
    .ve_out        (ve),
    .locked_out    (locked),
    .slip_out      (slip),
    .err_count_out (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_tok(input logic [9:0] w);
    return (w == T0) || (w == T1) || (w == T2) || (w == T3);
  endfunction

  // Reference DVI TMDS encoder with running disparity.
  task automatic tmds_enc(input logic [7:0] din, output logic [9:0] q);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1 = $countones(din);
    qm[0] = din[0];
    if (n1 > 4 || (n1 == 4 && din[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ din[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ din[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q[9]   = ~qm[8];
      q[8]   = qm[8];
      q[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
      if (qm[8]) disp += n1q - n0q;
      else disp += n0q - n1q;
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += -(qm[8] ? 0 : 2) + n1q - n0q;
    end
  endtask

  task automatic do_reset(input logic [9:0] w);
    @(negedge clk);
    rst  = 1'b0;
    tmds = w;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst  = 1'b0;
    tmds = T0;
    repeat (2) @(negedge clk);
    total++;
    if ({data, control, ve, locked, slip, err_count} !== 32'd0)
      $display("FAIL reset_state: got %h want 0",
               {data, control, ve, locked, slip, err_count});
    else passed++;
  endtask

  task automatic test_aligned_lock;
    bit got = 0;
    do_reset(T0);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (locked) begin
        got = 1;
        break;
      end
    end
    total++;
    if (!got) $display("FAIL aligned_lock: locked=%b want 1 within 11", locked);
    else passed++;
    total++;
    if ({control, ve, slip} !== 7'd0)
      $display("FAIL aligned_ctrl: ctl/ve/slip=%b want 0", {control, ve, slip});
    else passed++;
  endtask

  task automatic test_control;
    logic [9:0] toks[4];
    logic [1:0] exps[4];
    toks[0] = T1; exps[0] = 2'b01;
    toks[1] = T2; exps[1] = 2'b10;
    toks[2] = T3; exps[2] = 2'b11;
    toks[3] = T0; exps[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tmds = toks[i];
      repeat (3) @(negedge clk);
      total++;
      if ({locked, ve, control} !== {2'b10, exps[i]})
        $display("FAIL control_%0d: lk/ve/ctl=%b want %b", i,
                 {locked, ve, control}, {2'b10, exps[i]});
      else passed++;
    end
  endtask

  task automatic test_data;
    logic [9:0] q;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int n_inv = 0;
    disp = 0;
    for (int k = 0; k < 259; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        e = exp_q.pop_front();
        total++;
        if ({locked, ve, data} !== {2'b11, e})
          $display("FAIL data_%0d: lk/ve/data=%b want %b", k - 3,
                   {locked, ve, data}, {2'b11, e});
        else passed++;
      end
      if (k < 256) begin
        tmds_enc(8'(k), q);
        if (q[9]) n_inv++;
        exp_q.push_back(8'(k));
        tmds = q;
      end else begin
        tmds = T0;
      end
    end
    total++;
    if (n_inv == 0 || n_inv == 256)
      $display("FAIL data_branches: inverted=%0d want both", n_inv);
    else passed++;
  endtask

  task automatic test_timeout;
    repeat (12) begin
      @(negedge clk);
      tmds = T0;
    end
    for (int m = 1; m <= 4099; m++) begin
      @(negedge clk);
      if (m == 4098) begin
        total++;
        if (locked !== 1'b1) $display("FAIL timeout_hold: locked=%b want 1", locked);
        else passed++;
      end
      if (m == 4099) begin
        total++;
        if ({locked, ve, data} !== 10'd0)
          $display("FAIL timeout_drop: lk/ve/data=%b want 0", {locked, ve, data});
        else passed++;
        total++;
        if (slip !== 4'd1) $display("FAIL timeout_slip: slip=%0d want 1", slip);
        else passed++;
        total++;
        if (err_count !== ERR_EXP)
          $display("FAIL timeout_err: err=%0d want %0d", err_count, ERR_EXP);
        else passed++;
      end
      tmds = VID0;
    end
  endtask

  task automatic test_no_sync;
    logic [9:0] w;
    logic [3:0] es;
    do_reset(10'h155);
    for (int n = 1; n <= 180; n++) begin
      @(negedge clk);
      es = 4'((n / 16) % 10);
      total++;
      if ({locked, slip} !== {1'b0, es})
        $display("FAIL no_sync_%0d: lk/slip=%b want %b", n, {locked, slip}, {1'b0, es});
      else passed++;
      do w = 10'($urandom); while (is_tok(w));
      tmds = w;
    end
  endtask

  task automatic shifted_search(input string tag);
    bit got = 0;
    for (int n = 1; n <= 123; n++) begin
      @(negedge clk);
      if (n == 8 || n == 50) begin
        total++;
        if (slip !== 4'(n / 16))
          $display("FAIL %s_step%0d: slip=%0d want %0d", tag, n, slip, n / 16);
        else passed++;
      end
      if (locked) begin
        got = 1;
        break;
      end
    end
    total++;
    if (!got) $display("FAIL %s_lock: locked=%b want 1 within 123", tag, locked);
    else passed++;
    total++;
    if (slip !== 4'd7) $display("FAIL %s_slip: slip=%0d want 7", tag, slip);
    else passed++;
  endtask

  task automatic test_shifted_lock;
    logic [9:0] t;
    t = T0;
    do_reset({t[2:0], t[9:3]});
    shifted_search("shift");
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({data, control, ve, locked, slip, err_count} !== 32'd0)
      $display("FAIL mid_reset: got %h want 0",
               {data, control, ve, locked, slip, err_count});
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    shifted_search("relock");
  endtask

  initial begin
    rst  = 1'b0;
    tmds = '0;
    test_reset;
    test_aligned_lock;
    test_control;
    test_data;
    test_timeout;
    test_no_sync;
    test_shifted_lock;
    test_reset_midstream;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
